// File: rtl/inst_axi_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : inst_axi_burst_reader
// Purpose  : Instruction-side AXI read master. It accepts one cache-line
//            refill request, issues one AR burst of LINE_WORDS beats, and
//            forwards each R beat to the I-cache together with its word index.
//            The final beat carries last/error status. Only one transaction
//            is in flight at a time.
// Ports    : clk, reset (sync, active-high), enable (gates new requests only)
//            req_valid/req_addr/req_ready    - refill request from the cache
//            resp_valid/data/index/last/error - per-word response pulses
//            AR* / R*                        - AXI read address/data channels
// Options  : `define INST_WRAP_BURST_EN selects a critical-word-first WRAP
//            burst that starts at the missed word, and rotated resp_index.
// Revision : 1.0 - initial release
// ============================================================================
module inst_axi_burst_reader #(
  parameter int LINE_WORDS = 8,
  parameter int ID_W       = 4,
  parameter int AXI_ID     = 0,
  localparam int IDX_W     = $clog2(LINE_WORDS),
  localparam int OFF_W     = IDX_W + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  output logic [IDX_W-1:0] resp_index,
  output logic             resp_last,
  output logic             resp_error,
  output logic [ID_W-1:0]  ARID,
  output logic [31:0]      ARADDR,
  output logic [7:0]       ARLEN,
  output logic [2:0]       ARSIZE,
  output logic [1:0]       ARBURST,
  output logic [1:0]       ARLOCK,
  output logic [3:0]       ARCACHE,
  output logic [2:0]       ARPROT,
  output logic             ARVALID,
  input  logic             ARREADY,
  input  logic [ID_W-1:0]  RID,
  input  logic [31:0]      RDATA,
  input  logic [1:0]       RRESP,
  input  logic             RLAST,
  input  logic             RVALID,
  output logic             RREADY
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LINE_WORDS - 1);
  localparam logic [ID_W-1:0]  c_axi_id   = ID_W'(AXI_ID);
  localparam logic [7:0]       c_arlen    = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic             r_err_flag;
  logic [IDX_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_last_beat;
  logic             w_beat_err;
  logic [31:0]      w_araddr;
  logic [1:0]       w_arburst;
  logic [IDX_W-1:0] w_index;
  logic             w_unused_addr;

  assign req_ready   = (r_state == S_IDLE) && enable;
  assign RREADY      = (r_state == S_DATA);
  assign w_accept    = req_valid && req_ready;
  assign w_ar_hs     = (r_state == S_ADDR) && ARREADY;
  assign w_r_hs      = RVALID && RREADY;
  // The burst length is owned by our counter, not by RLAST; a misplaced
  // RLAST is only reported as an error.
  assign w_last_beat = (r_cnt == c_last_idx);
  assign w_beat_err  = (RRESP != 2'b00) || (RID != c_axi_id) ||
                       (RLAST != w_last_beat);

`ifdef INST_WRAP_BURST_EN
  logic [IDX_W-1:0] r_start_word;

  // The slave wraps at the line boundary, so the missed word comes back first.
  assign w_araddr      = {req_addr[31:2], 2'b00};
  assign w_arburst     = 2'b10;
  assign w_index       = r_start_word + r_cnt;  // wraps modulo LINE_WORDS
  assign w_unused_addr = ^req_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_word <= '0;
    end else if (w_accept) begin
      r_start_word <= req_addr[OFF_W-1:2];
    end
  end
`else
  assign w_araddr      = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign w_arburst     = 2'b01;
  assign w_index       = r_cnt;
  assign w_unused_addr = ^req_addr[OFF_W-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_ADDR;
      S_ADDR: if (ARREADY) w_next_state = S_DATA;
      S_DATA: if (w_r_hs && w_last_beat) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // AR channel, beat counter, sticky error and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ARVALID    <= 1'b0;
      ARID       <= '0;
      ARADDR     <= '0;
      ARLEN      <= '0;
      ARSIZE     <= '0;
      ARBURST    <= '0;
      ARLOCK     <= '0;
      ARCACHE    <= '0;
      ARPROT     <= '0;
      r_cnt      <= '0;
      r_err_flag <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_index <= '0;
      resp_last  <= 1'b0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_last  <= 1'b0;
      resp_error <= 1'b0;

      if (w_accept) begin
        ARVALID <= 1'b1;
        ARID    <= c_axi_id;
        ARADDR  <= w_araddr;
        ARLEN   <= c_arlen;
        ARSIZE  <= 3'b010;
        ARBURST <= w_arburst;
        ARLOCK  <= 2'b00;
        ARCACHE <= 4'b0000;
        ARPROT  <= 3'b000;
      end

      if (w_ar_hs) begin
        ARVALID    <= 1'b0;
        ARID       <= '0;
        ARADDR     <= '0;
        ARLEN      <= '0;
        ARSIZE     <= '0;
        ARBURST    <= '0;
        ARLOCK     <= '0;
        ARCACHE    <= '0;
        ARPROT     <= '0;
        r_cnt      <= '0;
        r_err_flag <= 1'b0;
      end

      if (w_r_hs) begin
        resp_valid <= 1'b1;
        resp_data  <= RDATA;
        resp_index <= w_index;
        resp_last  <= w_last_beat;
        resp_error <= w_last_beat && (r_err_flag || w_beat_err);
        r_cnt      <= r_cnt + 1'b1;
        r_err_flag <= r_err_flag || w_beat_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_axi_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_axi_burst_reader
// Purpose  : Directed self-checking bench for inst_axi_burst_reader with
//            LINE_WORDS=8. Expected values are hand-derived from the
//            request address and beat number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_axi_burst_reader;

  localparam int LW    = 8;
  localparam int IDX_W = 3;
  localparam int ID_W  = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             req_valid;
  logic [31:0]      req_addr;
  logic             req_ready;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic [IDX_W-1:0] resp_index;
  logic             resp_last;
  logic             resp_error;
  logic [ID_W-1:0]  ARID;
  logic [31:0]      ARADDR;
  logic [7:0]       ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;
  logic [1:0]       ARLOCK;
  logic [3:0]       ARCACHE;
  logic [2:0]       ARPROT;
  logic             ARVALID;
  logic             ARREADY;
  logic [ID_W-1:0]  RID;
  logic [31:0]      RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;
  logic             RVALID;
  logic             RREADY;

  int n_checks = 0;
  int n_fail   = 0;

  inst_axi_burst_reader #(
    .LINE_WORDS(LW),
    .ID_W      (ID_W),
    .AXI_ID    (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_index(resp_index),
    .resp_last (resp_last),
    .resp_error(resp_error),
    .ARID      (ARID),
    .ARADDR    (ARADDR),
    .ARLEN     (ARLEN),
    .ARSIZE    (ARSIZE),
    .ARBURST   (ARBURST),
    .ARLOCK    (ARLOCK),
    .ARCACHE   (ARCACHE),
    .ARPROT    (ARPROT),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected resp_index for beat i of a burst whose missed word is 'start'.
  function automatic logic [IDX_W-1:0] exp_idx(input int start, input int i);
`ifdef INST_WRAP_BURST_EN
    return IDX_W'((start + i) % LW);
`else
    return IDX_W'(i);
`endif
  endfunction

  // Request a line and complete the AR handshake immediately.
  task automatic start_burst(input logic [31:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    ARREADY   = 1'b1;
    tick();
    ARREADY   = 1'b0;
  endtask

  // Present one R beat for one cycle and return the response it produced.
  task automatic drive_beat(input logic [31:0] data, input logic [1:0] rresp,
                            input logic [ID_W-1:0] rid, input logic rlast,
                            output logic v, output logic [31:0] d,
                            output logic [IDX_W-1:0] idx, output logic l,
                            output logic e);
    RVALID = 1'b1;
    RDATA  = data;
    RRESP  = rresp;
    RID    = rid;
    RLAST  = rlast;
    tick();
    RVALID = 1'b0;
    RRESP  = 2'b00;
    RID    = '0;
    RLAST  = 1'b0;
    v = resp_valid; d = resp_data; idx = resp_index; l = resp_last; e = resp_error;
  endtask

  task automatic test_reset();
    logic v, l, e;
    logic [31:0] d;
    logic [IDX_W-1:0] idx;
    reset = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT} !== '0) begin
      n_fail++;
      $display("FAIL reset_ar: ARVALID=%b ARADDR=%h ARLEN=%0d required all zero", ARVALID, ARADDR, ARLEN);
    end
    n_checks++;
    if ({resp_valid, resp_data, resp_index, resp_last, resp_error, RREADY, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: valid=%b data=%h idx=%0d last=%b err=%b rready=%b req_ready=%b required all zero",
               resp_valid, resp_data, resp_index, resp_last, resp_error, RREADY, req_ready);
    end
    reset = 1'b0;
    enable = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
    // Abandon a burst part-way through.
    start_burst(32'h1FC0_0014);
    drive_beat(32'hB0, 2'b00, '0, 1'b0, v, d, idx, l, e);
    drive_beat(32'hB1, 2'b00, '0, 1'b0, v, d, idx, l, e);
    RVALID = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    RVALID = 1'b0;
    n_checks++;
    if ({ARVALID, RREADY, resp_valid} !== 3'b000 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_reset: ARVALID=%b RREADY=%b resp_valid=%b req_ready=%b required 0,0,0,1",
               ARVALID, RREADY, resp_valid, req_ready);
    end
  endtask

  task automatic test_incr_burst();
    logic v, l, e;
    logic [31:0] d;
    logic [IDX_W-1:0] idx;
    logic [31:0] exp_addr;
    logic [1:0]  exp_burst;
`ifdef INST_WRAP_BURST_EN
    exp_addr = 32'h1FC0_0014; exp_burst = 2'b10;
`else
    exp_addr = 32'h1FC0_0000; exp_burst = 2'b01;
`endif
    req_valid = 1'b1;
    req_addr  = 32'h1FC0_0014;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (ARVALID !== 1'b1 || ARADDR !== exp_addr || ARLEN !== 8'd7 || ARSIZE !== 3'd2 ||
          ARBURST !== exp_burst || ARID !== 4'd0 || {ARLOCK, ARCACHE, ARPROT} !== '0) begin
        n_fail++;
        $display("FAIL ar_hold[%0d]: ARVALID=%b ARADDR=%h ARLEN=%0d ARSIZE=%0d ARBURST=%0d required 1 %h 7 2 %0d",
                 c, ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, exp_addr, exp_burst);
      end
      if (c == 3) ARREADY = 1'b1;
      tick();
    end
    ARREADY = 1'b0;
    n_checks++;
    if (ARVALID !== 1'b0 || ARADDR !== 32'h0 || ARLEN !== 8'd0 || RREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_done: ARVALID=%b ARADDR=%h ARLEN=%0d RREADY=%b required 0 0 0 1",
               ARVALID, ARADDR, ARLEN, RREADY);
    end
    for (int i = 0; i < LW; i++) begin
      drive_beat(32'hA0 + i, 2'b00, '0, i == LW - 1, v, d, idx, l, e);
      n_checks++;
      if (v !== 1'b1 || d !== 32'hA0 + i || idx !== exp_idx(5, i) || l !== (i == LW - 1) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL incr_beat[%0d]: v=%b d=%h idx=%0d last=%b err=%b required 1 %h %0d %b 0",
                 i, v, d, idx, l, e, 32'hA0 + i, exp_idx(5, i), i == LW - 1);
      end
    end
    n_checks++;
    if (RREADY !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL incr_end: RREADY=%b req_ready=%b required 0 1", RREADY, req_ready);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || resp_last !== 1'b0 || resp_data !== 32'hA7) begin
      n_fail++;
      $display("FAIL incr_idle: valid=%b last=%b data=%h required 0 0 a7", resp_valid, resp_last, resp_data);
    end
  endtask

  task automatic test_rvalid_gaps();
    logic v, l, e;
    logic [31:0] d;
    logic [IDX_W-1:0] idx;
    start_burst(32'h0000_2000);
    for (int i = 0; i < LW; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          n_checks++;
          if (resp_valid !== 1'b0 || resp_index !== exp_idx(0, 3) || resp_data !== 32'hC3) begin
            n_fail++;
            $display("FAIL gap[%0d]: valid=%b idx=%0d data=%h required 0 %0d c3",
                     g, resp_valid, resp_index, resp_data, exp_idx(0, 3));
          end
        end
      end
      drive_beat(32'hC0 + i, 2'b00, '0, i == LW - 1, v, d, idx, l, e);
      n_checks++;
      if (v !== 1'b1 || d !== 32'hC0 + i || idx !== exp_idx(0, i) || l !== (i == LW - 1) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_beat[%0d]: v=%b d=%h idx=%0d last=%b err=%b required 1 %h %0d %b 0",
                 i, v, d, idx, l, e, 32'hC0 + i, exp_idx(0, i), i == LW - 1);
      end
    end
  endtask

  task automatic test_errors_back_to_back();
    logic v, l, e;
    logic [31:0] d;
    logic [IDX_W-1:0] idx;
    start_burst(32'h0000_3000);
    for (int i = 0; i < LW; i++) begin
      drive_beat(32'hD0 + i, (i == 2) ? 2'b10 : 2'b00, (i == 5) ? 4'd1 : 4'd0,
                 i == LW - 1, v, d, idx, l, e);
      n_checks++;
      if (v !== 1'b1 || d !== 32'hD0 + i || l !== (i == LW - 1) || e !== (i == LW - 1)) begin
        n_fail++;
        $display("FAIL err_beat[%0d]: v=%b d=%h last=%b err=%b required 1 %h %b %b",
                 i, v, d, l, e, 32'hD0 + i, i == LW - 1, i == LW - 1);
      end
    end
    // A new request is accepted while resp_last is visible.
    n_checks++;
    if (req_ready !== 1'b1 || resp_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: req_ready=%b resp_last=%b required 1 1", req_ready, resp_last);
    end
    start_burst(32'h0000_4000);
    for (int i = 0; i < LW; i++) begin
      drive_beat(32'hE0 + i, 2'b00, '0, i == LW - 1, v, d, idx, l, e);
      n_checks++;
      if (v !== 1'b1 || d !== 32'hE0 + i || e !== 1'b0 || l !== (i == LW - 1)) begin
        n_fail++;
        $display("FAIL clean_after_err[%0d]: v=%b d=%h err=%b last=%b required 1 %h 0 %b",
                 i, v, d, e, l, 32'hE0 + i, i == LW - 1);
      end
    end
    // RLAST early on beat 3 is an error and must not end the burst.
    start_burst(32'h0000_5000);
    for (int i = 0; i < LW; i++) begin
      drive_beat(32'hF0 + i, 2'b00, '0, i == 3, v, d, idx, l, e);
      n_checks++;
      if (v !== 1'b1 || l !== (i == LW - 1) || e !== (i == LW - 1)) begin
        n_fail++;
        $display("FAIL rlast_err[%0d]: v=%b last=%b err=%b required 1 %b %b",
                 i, v, l, e, i == LW - 1, i == LW - 1);
      end
    end
  endtask

  task automatic test_enable();
    logic v, l, e;
    logic [31:0] d;
    logic [IDX_W-1:0] idx;
    enable = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h0000_6000;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_ready: got %b required 0", req_ready);
    end
    tick();
    tick();
    n_checks++;
    if (ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_noar: ARVALID=%b required 0", ARVALID);
    end
    req_valid = 1'b0;
    enable = 1'b1;
    start_burst(32'h0000_6000);
    for (int i = 0; i < LW; i++) begin
      if (i == 2) enable = 1'b0;
      drive_beat(32'h60 + i, 2'b00, '0, i == LW - 1, v, d, idx, l, e);
      n_checks++;
      if (v !== 1'b1 || d !== 32'h60 + i || l !== (i == LW - 1) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_beat[%0d]: v=%b d=%h last=%b err=%b required 1 %h %b 0",
                 i, v, d, l, e, 32'h60 + i, i == LW - 1);
      end
    end
    enable = 1'b1;
  endtask

`ifdef INST_WRAP_BURST_EN
  task automatic test_wrap();
    logic v, l, e;
    logic [31:0] d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] exp_seq [LW] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    req_valid = 1'b1;
    req_addr = 32'h0000_1014;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (ARADDR !== 32'h0000_1014 || ARBURST !== 2'b10 || ARVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_ar: ARADDR=%h ARBURST=%0d ARVALID=%b required 00001014 2 1", ARADDR, ARBURST, ARVALID);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    for (int i = 0; i < LW; i++) begin
      drive_beat(32'h90 + i, 2'b00, '0, i == LW - 1, v, d, idx, l, e);
      n_checks++;
      if (v !== 1'b1 || idx !== exp_seq[i] || l !== (i == LW - 1)) begin
        n_fail++;
        $display("FAIL wrap_idx[%0d]: v=%b idx=%0d last=%b required 1 %0d %b", i, v, idx, l, exp_seq[i], i == LW - 1);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; req_valid = 1'b0; req_addr = '0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    test_reset();
    test_incr_burst();
    test_rvalid_gaps();
    test_errors_back_to_back();
    test_enable();
`ifdef INST_WRAP_BURST_EN
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
